// File: rtl/cla_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cla_seq_pkg
// Brief    : Shared state encoding and index-width helper for the nibble
//            sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package cla_seq_pkg;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_add  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    // Width of the nibble index, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla4_cin.sv
`default_nettype none
// ============================================================================
// Module   : cla4_cin
// Brief    : 4-bit carry-lookahead adder with carry-in.
// Revision : 1.0 - initial release
// ============================================================================
module cla4_cin (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Every carry is a flat sum of products of g/p and cin.
    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_sum  = w_p ^ w_c[3:0];
    assign o_cout = w_c[4];

endmodule
`default_nettype wire

// File: rtl/cla_nibble_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cla_nibble_sequencer
// Brief    : Sequences an external 4-bit CLA across a wide operand, LSB
//            nibble first, with optional accumulate of the previous result.
// Revision : 1.0 - initial release
// ============================================================================
module cla_nibble_sequencer
    import cla_seq_pkg::*;
#(
    parameter int NIBBLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 acc,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic [3:0]           cla_a,
    output logic [3:0]           cla_b,
    output logic                 cla_cin,
    input  logic [3:0]           cla_sum,
    input  logic                 cla_cout,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = idx_width(NIBBLES);
    localparam logic [IW-1:0] c_last_idx = IW'(NIBBLES - 1);

    logic [1:0]    r_state;
    logic [IW-1:0] r_idx;
    logic          r_carry;
    logic [W-1:0]  r_op_a;
    logic [W-1:0]  r_op_b;
    logic [W-1:0]  r_res;
    logic [W-1:0]  r_sum;
    logic          r_cout;
    logic [W-1:0]  w_res_next;

    always_comb begin
        w_res_next = r_res;
        w_res_next[4*r_idx +: 4] = cla_sum;
    end

    always_comb begin
        cla_a   = 4'd0;
        cla_b   = 4'd0;
        cla_cin = 1'b0;
        if (r_state == c_add) begin
            cla_a   = r_op_a[4*r_idx +: 4];
            cla_b   = r_op_b[4*r_idx +: 4];
            cla_cin = r_carry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_idle;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_op_a  <= acc ? r_sum : a;
                        r_op_b  <= b;
                        r_idx   <= '0;
                        r_carry <= 1'b0;
                        r_state <= c_add;
                    end
                end
                c_add: begin
                    r_res   <= w_res_next;
                    r_carry <= cla_cout;
                    // Commit on the DONE-entry edge so the result shows with done.
                    if (r_idx == c_last_idx) begin
                        r_sum   <= w_res_next;
                        r_cout  <= cla_cout;
                        r_state <= c_done;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                c_done:  r_state <= c_idle;
                default: r_state <= c_idle;
            endcase
        end
    end

    assign busy = (r_state == c_add);
    assign done = (r_state == c_done);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
`default_nettype wire
